// File: rtl/sm_muldiv.sv
// Iterative radix-2 multiply/divide engine with HI/LO result registers.
// Signed ops run on magnitudes; the FIX state applies sign correction.
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             kill,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_div;
    logic               r_negq;
    logic               r_negr;
    logic               r_dz;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_s;
    logic               w_accept;

    assign w_a_neg  = op[0] & srcA[WIDTH-1];
    assign w_b_neg  = op[0] & srcB[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -srcA : srcA;
    assign w_b_mag  = w_b_neg ? -srcB : srcB;

    // Multiply: add-and-shift, low product bits enter r_q from the top.
    assign w_sum    = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);

    // Divide: restoring step, bit WIDTH of w_diff is the borrow.
    assign w_rem    = {r_acc, r_q[WIDTH-1]};
    assign w_diff   = w_rem - {1'b0, r_b};

    assign w_prod   = {r_acc, r_q};
    assign w_prod_s = r_negq ? -w_prod : w_prod;

    // A new request may also be taken on the FIX edge for gapless issue.
    assign w_accept = start & ~kill &
                      ((r_state == S_IDLE) | (r_state == S_FIX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_negq  <= 1'b0;
            r_negr  <= 1'b0;
            r_dz    <= 1'b0;
            r_b     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_CALC: begin
                    if (kill) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        if (r_div) begin
                            if (!w_diff[WIDTH]) begin
                                r_acc <= w_diff[WIDTH-1:0];
                                r_q   <= {r_q[WIDTH-2:0], 1'b1};
                            end else begin
                                r_acc <= w_rem[WIDTH-1:0];
                                r_q   <= {r_q[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            r_acc <= w_sum[WIDTH:1];
                            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    if (!kill) begin
                        r_done <= 1'b1;
                        if (r_div) begin
                            r_hi <= r_negr ? -r_acc : r_acc;
                            r_lo <= r_dz ? '1 : (r_negq ? -r_q : r_q);
                        end else begin
                            r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_s[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
            if (w_accept) begin
                r_state <= S_CALC;
                r_busy  <= 1'b1;
                r_cnt   <= CW'(WIDTH);
                r_div   <= op[1];
                r_negq  <= w_a_neg ^ w_b_neg;
                r_negr  <= w_a_neg;
                r_dz    <= (srcB == '0);
                r_b     <= w_b_mag;
                r_acc   <= '0;
                r_q     <= w_a_mag;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_sm_muldiv.sv
// Directed bench for sm_muldiv: 32-bit vectors plus an 8-bit
// instance checked against an integer reference model.
module tb_sm_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        kill;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        start8;
    logic [1:0]  op8;
    logic        kill8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0;
    int lat;
    int viol;

    sm_muldiv #(.WIDTH(32)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .kill  (kill),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    sm_muldiv #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .op    (op8),
        .kill  (kill8),
        .srcA  (a8),
        .srcB  (b8),
        .busy  (busy8),
        .done  (done8),
        .hi    (hi8),
        .lo    (lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srcA  = a;
        srcB  = b;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 999;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el);
        launch(o, a, b);
        wait_done();
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_hilo"}, {hi, lo}, {eh, el});
    endtask

    function automatic logic [15:0] ref8(input logic [1:0] o,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        int sa;
        int sb;
        int q;
        int r;
        sa = o[0] ? int'($signed(a)) : int'(a);
        sb = o[0] ? int'($signed(b)) : int'(b);
        if (!o[1])
            return 16'(sa * sb);
        if (b == 8'h00)
            return {a, 8'hFF};
        q = sa / sb;
        r = sa % sb;
        return {r[7:0], q[7:0]};
    endfunction

    logic [7:0] ca [8] = '{8'h00, 8'hFF, 8'h80, 8'h7F,
                           8'h80, 8'h05, 8'hF9, 8'h64};
    logic [7:0] cb [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00,
                           8'h80, 8'hFE, 8'h02, 8'h07};

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        kill   = 1'b0;
        srcA   = '0;
        srcB   = '0;
        start8 = 1'b0;
        op8    = 2'b00;
        kill8  = 1'b0;
        a8     = '0;
        b8     = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", {busy, done, hi, lo}, '0);
        rst_n = 1'b1;

        // reset asserted in the middle of CALC
        launch(2'b00, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy || done || hi != 0 || lo != 0)
                viol++;
        end
        chk("rst_idle40", 64'(viol), 64'd0);

        run("multu_ff", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'hFFFFFFFE, 32'h00000001);
        run("mult_m3x7", 2'b01, 32'hFFFFFFFD, 32'd7,
            32'hFFFFFFFF, 32'hFFFFFFEB);
        run("mult_m1m1", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'h00000000, 32'h00000001);
        run("mult_min", 2'b01, 32'h80000000, 32'h80000000,
            32'h40000000, 32'h00000000);
        run("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        run("div_m7_2", 2'b11, 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        run("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF,
            32'h00000000, 32'h80000000);
        run("divu_dz", 2'b10, 32'h1234, 32'd0,
            32'h00001234, 32'hFFFFFFFF);
        run("div_dz", 2'b11, 32'h1234, 32'd0,
            32'h00001234, 32'hFFFFFFFF);
        run("div_dzneg", 2'b11, 32'hFFFFEDCC, 32'd0,
            32'hFFFFEDCC, 32'hFFFFFFFF);

        // start while busy is ignored; operand changes have no effect
        launch(2'b10, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        op    = 2'b00;
        srcA  = 32'd5;
        srcB  = 32'd5;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done();
        chk("ign_lat", 64'(lat), 64'd33);
        chk("ign_hilo", {hi, lo}, {32'd2, 32'd14});

        // back-to-back issue with start held over the done cycle
        launch(2'b00, 32'd6, 32'd7);
        viol = 0;
        while (cyc < t0 + 32) begin
            @(posedge clk);
            #1;
            if (!busy) viol++;
        end
        start = 1'b1;
        op    = 2'b10;
        srcA  = 32'd100;
        srcB  = 32'd7;
        @(posedge clk);
        #1;
        chk("b2b_done1", 64'(done), 64'd1);
        chk("b2b_hilo1", {hi, lo}, {32'd0, 32'd42});
        t0 = cyc;
        if (!busy) viol++;
        @(posedge clk);
        #1 start = 1'b0;
        if (!busy) viol++;
        lat = 999;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = cyc - t0;
                break;
            end
            if (!busy) viol++;
        end
        chk("b2b_busy_gap", 64'(viol), 64'd0);
        chk("b2b_lat2", 64'(lat), 64'd33);
        chk("b2b_hilo2", {hi, lo}, {32'd2, 32'd14});

        // kill at CALC cycle 10
        launch(2'b00, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        chk("kill_busy", {63'd0, busy}, 64'd0);
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) viol++;
        end
        chk("kill_nodone", 64'(viol), 64'd0);
        chk("kill_hilo", {hi, lo}, {32'd2, 32'd14});

        // kill beats start in IDLE
        @(negedge clk);
        start = 1'b1;
        kill  = 1'b1;
        op    = 2'b00;
        srcA  = 32'd1;
        srcB  = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_idle", 64'(busy), 64'd0);

        // 8-bit instance against the reference model
        viol = 0;
        for (int o = 0; o < 4; o++) begin
            for (int i = 0; i < 32; i++) begin
                logic [15:0] exp8;
                logic [7:0]  va;
                logic [7:0]  vb;
                int          l8;
                if (i < 8) begin
                    va = ca[i];
                    vb = cb[i];
                end else begin
                    va = 8'($urandom_range(0, 255));
                    vb = 8'($urandom_range(0, 255));
                end
                @(negedge clk);
                start8 = 1'b1;
                op8    = 2'(o);
                a8     = va;
                b8     = vb;
                @(posedge clk);
                #1;
                t0     = cyc;
                start8 = 1'b0;
                l8     = 999;
                for (int n = 0; n < 20; n++) begin
                    @(posedge clk);
                    #1;
                    if (done8) begin
                        l8 = cyc - t0;
                        break;
                    end
                end
                exp8 = ref8(2'(o), va, vb);
                chk($sformatf("w8_op%0d_%h_%h", o, va, vb),
                    {hi8, lo8}, 64'(exp8));
                if (l8 != 9) viol++;
            end
        end
        chk("w8_latency", 64'(viol), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
